// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side and game-core-side signals of the keypad scanner.
// The scanner takes the master modport; the keypad/game-core side takes the slave modport.
interface keypad_scan_debounce_if;
    logic [3:0] keypadCol;
    logic [3:0] keypadRow;
    logic [3:0] keypadBuf;
    logic       key_valid;
    logic       key_pulse;

    modport master (
        input  keypadCol,
        output keypadRow,
        output keypadBuf,
        output key_valid,
        output key_pulse
    );

    modport slave (
        output keypadCol,
        input  keypadRow,
        input  keypadBuf,
        input  key_valid,
        input  key_pulse
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with ghost rejection and whole-scan debounce.
// Delivers a stable key code, a level valid flag and a one-cycle new-press strobe.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_scan_debounce_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       drive_q, drive_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             prev_single_q, prev_single_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [3:0]       buf_q, buf_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;

    logic [1:0] row_cnt;
    logic [3:0] row_code;
    logic [2:0] sum_cnt;
    logic [1:0] tot_cnt;
    logic [3:0] merged_code;
    logic       res_single;
    logic [3:0] res_code;

    // Press count (saturating at 2) and code of the columns pulled low in the driven row.
    always_comb begin
        row_cnt  = 2'd0;
        row_code = 4'd0;
        for (int c = 0; c < 4; c++) begin
            if (!kp.keypadCol[c]) begin
                if (row_cnt != 2'd2) begin
                    row_cnt = row_cnt + 2'd1;
                end
                row_code = {row_q, 2'(c)};
            end
        end
    end

    always_comb begin
        sum_cnt     = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
        tot_cnt     = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        merged_code = (row_cnt != 2'd0) ? row_code : acc_code_q;
    end

    always_comb begin
        div_d         = div_q;
        row_d         = row_q;
        drive_d       = drive_q;
        acc_cnt_d     = acc_cnt_q;
        acc_code_d    = acc_code_q;
        prev_single_d = prev_single_q;
        prev_code_d   = prev_code_q;
        stable_d      = stable_q;
        buf_d         = buf_q;
        valid_d       = valid_q;
        pulse_d       = 1'b0;
        res_single    = 1'b0;
        res_code      = 4'd0;

        if (div_q == DIV_LAST) begin
            div_d   = '0;
            row_d   = row_q + 2'd1;
            drive_d = {drive_q[2:0], drive_q[3]};

            if (row_q != 2'd3) begin
                acc_cnt_d  = tot_cnt;
                acc_code_d = merged_code;
            end else begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
                // NONE and MULTI share one encoding (code forced to 0) so ghosts debounce as "no key".
                res_single = (tot_cnt == 2'd1);
                res_code   = res_single ? merged_code : 4'd0;

                if (res_single == prev_single_q && res_code == prev_code_q) begin
                    if (stable_q != STB_MAX) begin
                        stable_d = stable_q + STB_W'(1);
                    end
                end else begin
                    stable_d      = STB_W'(1);
                    prev_single_d = res_single;
                    prev_code_d   = res_code;
                end

                if (stable_d == STB_MAX) begin
                    if (res_single) begin
                        if (!valid_q || res_code != buf_q) begin
                            buf_d   = res_code;
                            valid_d = 1'b1;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            row_q         <= 2'd0;
            drive_q       <= 4'b1110;
            acc_cnt_q     <= 2'd0;
            acc_code_q    <= 4'd0;
            prev_single_q <= 1'b0;
            prev_code_q   <= 4'd0;
            stable_q      <= '0;
            buf_q         <= 4'd0;
            valid_q       <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            div_q         <= div_d;
            row_q         <= row_d;
            drive_q       <= drive_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_code_q    <= acc_code_d;
            prev_single_q <= prev_single_d;
            prev_code_q   <= prev_code_d;
            stable_q      <= stable_d;
            buf_q         <= buf_d;
            valid_q       <= valid_d;
            pulse_q       <= pulse_d;
        end
    end

    assign kp.keypadRow = drive_q;
    assign kp.keypadBuf = buf_q;
    assign kp.key_valid = valid_q;
    assign kp.key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a behavioural 4x4 key matrix.
// SCAN_DIV=4, DEBOUNCE_SCANS=2: one scan is 16 clocks, scan ends every 16th edge after reset release.
module tb_keypad_scan_debounce;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        logic [3:0]  exp_buf;
        logic        exp_valid;
        int          exp_pulses;
        bit          hold_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  col_drive;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[19];

    keypad_scan_debounce_if kpif ();

    keypad_scan_debounce #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .kp(kpif.master)
    );

    always #5 clk = ~clk;

    // Key matrix: a held key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_drive = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kpif.keypadRow[r] && keys[r*4+c]) begin
                    col_drive[c] = 1'b0;
                end
            end
        end
    end

    assign kpif.keypadCol = col_drive;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int scans, output int pulses, output bit valid_all);
        keys      = k;
        pulses    = 0;
        valid_all = 1'b1;
        repeat (16 * scans) begin
            @(negedge clk);
            if (kpif.key_pulse === 1'b1) pulses++;
            if (kpif.key_valid !== 1'b1) valid_all = 1'b0;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_row"},   32'(kpif.keypadRow), 32'h0000000E);
        checkOutput({tag, "_buf"},   32'(kpif.keypadBuf), 32'h0);
        checkOutput({tag, "_valid"}, 32'(kpif.key_valid), 32'h0);
        checkOutput({tag, "_pulse"}, 32'(kpif.key_pulse), 32'h0);
    endtask

    initial begin
        int          pulses;
        bit          valid_all;
        logic [3:0]  exp_row;

        vecs[0]  = '{16'h0200, 1, 4'h0, 1'b0, 0, 1'b0};
        vecs[1]  = '{16'h0200, 1, 4'h9, 1'b1, 1, 1'b0};
        vecs[2]  = '{16'h0200, 5, 4'h9, 1'b1, 0, 1'b1};
        vecs[3]  = '{16'h0000, 1, 4'h9, 1'b1, 0, 1'b1};
        vecs[4]  = '{16'h0000, 1, 4'h9, 1'b0, 0, 1'b0};
        vecs[5]  = '{16'h0200, 2, 4'h9, 1'b1, 1, 1'b0};
        vecs[6]  = '{16'h0008, 1, 4'h9, 1'b1, 0, 1'b1};
        vecs[7]  = '{16'h0008, 1, 4'h3, 1'b1, 1, 1'b1};
        vecs[8]  = '{16'h0000, 2, 4'h3, 1'b0, 0, 1'b0};
        vecs[9]  = '{16'h0020, 1, 4'h3, 1'b0, 0, 1'b0};
        vecs[10] = '{16'h0000, 2, 4'h3, 1'b0, 0, 1'b0};
        vecs[11] = '{16'h8001, 3, 4'h3, 1'b0, 0, 1'b0};
        vecs[12] = '{16'h0001, 1, 4'h3, 1'b0, 0, 1'b0};
        vecs[13] = '{16'h0001, 1, 4'h0, 1'b1, 1, 1'b0};
        vecs[14] = '{16'h8001, 2, 4'h0, 1'b0, 0, 1'b0};
        vecs[15] = '{16'h8000, 2, 4'hF, 1'b1, 1, 1'b0};
        vecs[16] = '{16'h0000, 2, 4'hF, 1'b0, 0, 1'b0};
        vecs[17] = '{16'h0003, 2, 4'hF, 1'b0, 0, 1'b0};
        vecs[18] = '{16'h0040, 2, 4'h6, 1'b1, 1, 1'b0};

        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;

        // First scan: row drive steps every 4 clocks, no pulse.
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            checkOutput($sformatf("row_k%0d", k), 32'(kpif.keypadRow), 32'(exp_row));
            if (kpif.key_pulse === 1'b1) pulses++;
        end
        checkOutput("idle_first_scan_pulses", 32'(pulses), 32'h0);

        applyStimulus(16'h0000, 9, pulses, valid_all);
        checkOutput("idle_pulses", 32'(pulses), 32'h0);
        checkOutput("idle_buf", 32'(kpif.keypadBuf), 32'h0);
        checkOutput("idle_valid", 32'(kpif.key_valid), 32'h0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].keys, vecs[i].scans, pulses, valid_all);
            checkOutput($sformatf("vec%0d_buf", i), 32'(kpif.keypadBuf), 32'(vecs[i].exp_buf));
            checkOutput($sformatf("vec%0d_valid", i), 32'(kpif.key_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            if (vecs[i].hold_valid) begin
                checkOutput($sformatf("vec%0d_valid_held", i), 32'(valid_all), 32'h1);
            end
        end

        // Reset asserted one scan into a press of key 9, between clock edges.
        applyStimulus(16'h0200, 1, pulses, valid_all);
        checkOutput("pre_reset_valid", 32'(kpif.key_valid), 32'h1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkReset("async_reset");
        repeat (2) @(negedge clk);
        checkReset("held_reset");
        rst_n = 1'b1;

        applyStimulus(16'h0200, 1, pulses, valid_all);
        checkOutput("post_reset_scan1_valid", 32'(kpif.key_valid), 32'h0);
        checkOutput("post_reset_scan1_buf", 32'(kpif.keypadBuf), 32'h0);
        checkOutput("post_reset_scan1_pulses", 32'(pulses), 32'h0);
        applyStimulus(16'h0200, 1, pulses, valid_all);
        checkOutput("post_reset_scan2_valid", 32'(kpif.key_valid), 32'h1);
        checkOutput("post_reset_scan2_buf", 32'(kpif.keypadBuf), 32'h9);
        checkOutput("post_reset_scan2_pulses", 32'(pulses), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
